// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens, aligner states and 8-bit decode
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

    // Undo the optional inversion (bit 9), then undo the xor/xnor chain (bit 8 selects xor).
    function automatic logic [7:0] tmds_dec8(input logic [9:0] din);
        logic [7:0] q;
        logic [7:0] d;
        q    = din[9] ? ~din[7:0] : din[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// rtl/tmds_align_fsm.sv - word-boundary search, bit-slip sequencing and lock supervision
module tmds_align_fsm
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_WAIT      = 16,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_1x,
    input  logic       rst_n,
    input  logic       tok_vld,
    output logic       locked,
    output logic       lock_nxt,
    output logic       bitslip,
    output logic [3:0] slip_cnt
);

    localparam int RUN_W  = $clog2(CTRL_RUN) + 1;
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0]  RUN_LIM  = RUN_W'(CTRL_RUN);
    localparam logic [TMO_W-1:0]  TMO_LIM  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LIM = LOSS_W'(LOSS_TIMEOUT);

    align_state_t      state, state_nxt;
    logic [RUN_W-1:0]  run_cnt, run_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [LOSS_W-1:0] loss_cnt, loss_nxt;
    logic [3:0]        slip_nxt;

    // State and counter registers; reset abandons any slip in progress.
    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            wait_cnt <= '0;
            loss_cnt <= '0;
            slip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_nxt;
            tmo_cnt  <= tmo_nxt;
            wait_cnt <= wait_nxt;
            loss_cnt <= loss_nxt;
            slip_cnt <= slip_nxt;
        end
    end

    // Next state and counters; a completed token run beats a simultaneous search timeout.
    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        tmo_nxt   = tmo_cnt;
        wait_nxt  = wait_cnt;
        loss_nxt  = loss_cnt;
        slip_nxt  = slip_cnt;
        case (state)
            SEARCH: begin
                run_nxt = tok_vld ? run_cnt + 1'b1 : '0;
                tmo_nxt = tmo_cnt + 1'b1;
                if (run_nxt == RUN_LIM) begin
                    state_nxt = LOCKED;
                    loss_nxt  = '0;
                end else if (tmo_cnt == TMO_LIM) begin
                    state_nxt = SLIP;
                end
            end
            SLIP: begin
                slip_nxt  = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
                wait_nxt  = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                wait_nxt = wait_cnt + 1'b1;
                if (wait_cnt == WAIT_LIM) begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                    tmo_nxt   = '0;
                end
            end
            LOCKED: begin
                loss_nxt = tok_vld ? '0 : loss_cnt + 1'b1;
                if (loss_nxt == LOSS_LIM) begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                    tmo_nxt   = '0;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    assign locked   = (state == LOCKED);
    assign lock_nxt = (state_nxt == LOCKED);
    assign bitslip  = (state == SLIP);

endmodule

// File: rtl/tmds_decode_align.sv
// rtl/tmds_decode_align.sv - single-channel TMDS receive decoder with word aligner
module tmds_decode_align
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_WAIT      = 16,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_1x,
    input  logic       rst_n,
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       bitslip,
    output logic [3:0] slip_cnt,
    output logic       locked
);

    logic [9:0] din_r;
    logic       tok_vld;
    logic [1:0] tok_code;
    logic       tok_hit;
    logic [1:0] tok_val;
    logic       lock_nxt;

    // Classify the incoming word against the four control tokens.
    always_comb begin
        tok_hit = 1'b1;
        tok_val = 2'b00;
        case (din)
            TOK_C00: tok_val = 2'b00;
            TOK_C01: tok_val = 2'b01;
            TOK_C10: tok_val = 2'b10;
            TOK_C11: tok_val = 2'b11;
            default: tok_hit = 1'b0;
        endcase
    end

    // Stage 1: capture the word and its token classification.
    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n) begin
            din_r    <= '0;
            tok_vld  <= 1'b0;
            tok_code <= 2'b00;
        end else begin
            din_r    <= din;
            tok_vld  <= tok_hit;
            tok_code <= tok_val;
        end
    end

    // Stage 2: decode, gated by the lock state that becomes visible in the same cycle.
    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            de   <= 1'b0;
            c0   <= 1'b0;
            c1   <= 1'b0;
        end else if (!lock_nxt) begin
            dout <= '0;
            de   <= 1'b0;
            c0   <= 1'b0;
            c1   <= 1'b0;
        end else if (tok_vld) begin
            dout <= '0;
            de   <= 1'b0;
            c0   <= tok_code[0];
            c1   <= tok_code[1];
        end else begin
            dout <= tmds_dec8(din_r);
            de   <= 1'b1;
        end
    end

    tmds_align_fsm #(
        .CTRL_RUN      (CTRL_RUN),
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .SLIP_WAIT     (SLIP_WAIT),
        .LOSS_TIMEOUT  (LOSS_TIMEOUT)
    ) u_fsm (
        .clk_1x  (clk_1x),
        .rst_n   (rst_n),
        .tok_vld (tok_vld),
        .locked  (locked),
        .lock_nxt(lock_nxt),
        .bitslip (bitslip),
        .slip_cnt(slip_cnt)
    );

endmodule

// File: tb/tb_tmds_decode_align.sv
// tb/tb_tmds_decode_align.sv - randomized scoreboard bench for tmds_decode_align
module tb_tmds_decode_align;

    localparam int P_RUN  = 8;
    localparam int P_TMO  = 2048;
    localparam int P_WAIT = 16;
    localparam int P_LOSS = 4096;

    logic       clk_1x = 1'b0;
    logic       rst_n  = 1'b0;
    logic [9:0] din    = '0;
    logic [7:0] dout;
    logic       c0, c1, de, bitslip, locked;
    logic [3:0] slip_cnt;

    always #5 clk_1x = ~clk_1x;

    tmds_decode_align dut (
        .clk_1x  (clk_1x),
        .rst_n   (rst_n),
        .din     (din),
        .dout    (dout),
        .c0      (c0),
        .c1      (c1),
        .de      (de),
        .bitslip (bitslip),
        .slip_cnt(slip_cnt),
        .locked  (locked)
    );

    typedef struct {
        logic [7:0] dout;
        logic       de;
        logic       c0;
        logic       c1;
        logic       locked;
        logic       bitslip;
        logic [3:0] slip_cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         slip_at[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         off     = 0;
    logic [9:0] toks [4];
    logic [7:0] inv_tab [2][256];
    logic [9:0] t0;

    // Behavioural model state: phase 0 search, 1 slip, 2 settle, 3 locked.
    int         m_phase, m_streak, m_age, m_remain, m_quiet, m_slips, m_c;
    logic [9:0] m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int tok_idx(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == toks[i]) return i;
        return -1;
    endfunction

    // Transition-minimised encoding of a byte; the decode table is its inverse.
    function automatic logic [7:0] tmds_qm(input logic [7:0] b, input bit xor_mode);
        logic [7:0] q;
        q[0] = b[0];
        for (int i = 1; i < 8; i++) q[i] = xor_mode ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
        return q;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int k);
        logic [19:0] ww;
        ww = {w, w};
        return ww[19-k -: 10];
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (tok_idx(w) >= 0);
        return w;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_streak = 0; m_age = 0; m_remain = 0;
        m_quiet = 0; m_slips = 0; m_c = 0; m_prev = '0;
    endtask

    task automatic model_step(input logic [9:0] w, output exp_t e);
        int         k;
        logic [7:0] q;
        k = tok_idx(m_prev);
        case (m_phase)
            0: begin
                m_streak = (k >= 0) ? m_streak + 1 : 0;
                m_age++;
                if (m_streak == P_RUN) begin m_phase = 3; m_quiet = 0; end
                else if (m_age == P_TMO) m_phase = 1;
            end
            1: begin m_slips = (m_slips + 1) % 10; m_phase = 2; m_remain = P_WAIT; end
            2: begin
                m_remain--;
                if (m_remain == 0) begin m_phase = 0; m_streak = 0; m_age = 0; end
            end
            default: begin
                m_quiet = (k >= 0) ? 0 : m_quiet + 1;
                if (m_quiet == P_LOSS) begin m_phase = 0; m_streak = 0; m_age = 0; end
            end
        endcase
        e.locked   = (m_phase == 3);
        e.bitslip  = (m_phase == 1);
        e.slip_cnt = 4'(m_slips);
        if (!e.locked) begin
            m_c = 0; e.de = 1'b0; e.dout = '0;
        end else if (k >= 0) begin
            m_c = k; e.de = 1'b0; e.dout = '0;
        end else begin
            q      = m_prev[9] ? ~m_prev[7:0] : m_prev[7:0];
            e.de   = 1'b1;
            e.dout = inv_tab[m_prev[8]][q];
        end
        e.c0   = m_c[0];
        e.c1   = m_c[1];
        m_prev = w;
    endtask

    // Called at a negedge, returns at a negedge; the deserializer model reacts to bitslip.
    task automatic drive(input logic [9:0] w);
        exp_t e;
        din = rot(w, off);
        model_step(din, e);
        exp_q.push_back(e);
        @(posedge clk_1x);
        cyc++;
        #2;
        if (bitslip === 1'b1) begin
            slip_at.push_back(cyc);
            off = (off + 9) % 10;
        end
        @(negedge clk_1x);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        din   = '0;
        #1;
        chk({tag, " rst dout"}, 32'(dout), 32'd0);
        chk({tag, " rst de"}, 32'(de), 32'd0);
        chk({tag, " rst c1c0"}, 32'({c1, c0}), 32'd0);
        chk({tag, " rst locked"}, 32'(locked), 32'd0);
        chk({tag, " rst bitslip"}, 32'(bitslip), 32'd0);
        chk({tag, " rst slip_cnt"}, 32'(slip_cnt), 32'd0);
        model_reset();
        slip_at.delete();
        @(negedge clk_1x);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Scoreboard monitor: every post-edge sample is compared with the queued prediction.
    always @(posedge clk_1x) begin : mon
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dout", 32'(dout), 32'(e.dout));
            chk("de", 32'(de), 32'(e.de));
            chk("c0", 32'(c0), 32'(e.c0));
            chk("c1", 32'(c1), 32'(e.c1));
            chk("locked", 32'(locked), 32'(e.locked));
            chk("bitslip", 32'(bitslip), 32'(e.bitslip));
            chk("slip_cnt", 32'(slip_cnt), 32'(e.slip_cnt));
        end
    end

    initial begin
        toks[0] = 10'b1101010100;
        toks[1] = 10'b0010101011;
        toks[2] = 10'b0101010100;
        toks[3] = 10'b1010101011;
        t0      = toks[0];
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < 256; b++)
                inv_tab[m][tmds_qm(8'(b), m[0])] = 8'(b);
        model_reset();
        @(negedge clk_1x);

        // 1: lock on eight tokens
        off = 0;
        do_reset("t1");
        repeat (P_RUN) drive(t0);
        chk("t1 locked before", 32'(locked), 32'd0);
        drive(t0);
        chk("t1 locked", 32'(locked), 32'd1);
        chk("t1 de", 32'(de), 32'd0);
        chk("t1 c1c0", 32'({c1, c0}), 32'd0);
        chk("t1 slips", 32'(slip_at.size()), 32'd0);

        // 2: two data words decode two cycles later
        drive(10'b0100000000);
        drive(10'b1011111111);
        chk("t2 de0", 32'(de), 32'd1);
        chk("t2 dout0", 32'(dout), 32'h00);
        drive(t0);
        chk("t2 de1", 32'(de), 32'd1);
        chk("t2 dout1", 32'(dout), 32'hFE);
        chk("t2 c1c0", 32'({c1, c0}), 32'd0);
        repeat (4) drive(toks[$urandom_range(0, 3)]);
        repeat (40) drive(($urandom_range(0, 3) == 0) ? toks[$urandom_range(0, 3)] : rand_data());

        // 3: three bits off, token bursts of 16 with short data gaps
        off = 3;
        do_reset("t3");
        while (locked !== 1'b1 && cyc < 8000) begin
            repeat (16) drive(t0);
            repeat (4) drive(rand_data());
        end
        chk("t3 lock reached", 32'(locked), 32'd1);
        chk("t3 slip count", 32'(slip_at.size()), 32'd3);
        chk("t3 slip_cnt", 32'(slip_cnt), 32'd3);
        if (slip_at.size() == 3) begin
            chk("t3 first slip", 32'(slip_at[0]), 32'(P_TMO));
            chk("t3 gap1", 32'(slip_at[1] - slip_at[0]), 32'(P_TMO + P_WAIT + 1));
            chk("t3 gap2", 32'(slip_at[2] - slip_at[1]), 32'(P_TMO + P_WAIT + 1));
        end

        // 4: runs of seven tokens never lock; one slip at the timeout
        off = 0;
        do_reset("t4");
        repeat (375) begin
            repeat (7) drive(t0);
            drive(rand_data());
        end
        chk("t4 locked", 32'(locked), 32'd0);
        chk("t4 slip count", 32'(slip_at.size()), 32'd1);
        if (slip_at.size() == 1) chk("t4 slip cycle", 32'(slip_at[0]), 32'(P_TMO));

        // 5: loss of lock after a long token-free stretch, then relock without slipping
        off = 0;
        do_reset("t5");
        repeat (P_RUN + 1) drive(t0);
        chk("t5 locked", 32'(locked), 32'd1);
        repeat (P_LOSS) drive(rand_data());
        chk("t5 still locked", 32'(locked), 32'd1);
        drive(rand_data());
        chk("t5 lock lost", 32'(locked), 32'd0);
        chk("t5 de forced", 32'(de), 32'd0);
        repeat (3) drive(rand_data());
        chk("t5 de after", 32'(de), 32'd0);
        repeat (P_RUN + 1) drive(t0);
        chk("t5 relocked", 32'(locked), 32'd1);
        chk("t5 no slip", 32'(slip_at.size()), 32'd0);
        chk("t5 slip_cnt", 32'(slip_cnt), 32'd0);

        // 6: reset pulse during active data
        repeat (5) drive(rand_data());
        chk("t6 de active", 32'(de), 32'd1);
        do_reset("t6");
        repeat (P_RUN) drive(t0);
        chk("t6 not yet", 32'(locked), 32'd0);
        drive(t0);
        chk("t6 relocked", 32'(locked), 32'd1);
        repeat (20) drive(($urandom_range(0, 2) == 0) ? toks[$urandom_range(0, 3)] : rand_data());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_decode_align.md
Name: tmds_decode_align

Overview:
Single-channel TMDS receive decoder and word aligner. It is the receive-side counterpart of the team's VGA-to-HDMI transmit path. It takes 10-bit parallel words from an external deserializer, all in the clk_1x domain. It finds the correct word boundary by requesting bit slips until control tokens are seen, then decodes words back to 8-bit pixel data, c0/c1 and de. One instance is used per TMDS data channel (red, green, blue).

Parameters:
CTRL_RUN, 8, consecutive valid control tokens required to declare lock
SEARCH_TIMEOUT, 2048, clk_1x cycles in SEARCH without reaching CTRL_RUN before a bit slip is requested
SLIP_WAIT, 16, cycles to wait after a slip pulse for the deserializer to settle
LOSS_TIMEOUT, 4096, cycles in LOCKED without any control token before lock is dropped

Ports:
clk_1x  input  1  pixel clock; all logic is in this domain
rst_n  input  1  asynchronous active-low reset
din  input  10  parallel TMDS word from the deserializer; din[0] is the first bit on the wire
dout  output  8  decoded pixel byte
c0  output  1  decoded control bit 0 (hsync on the blue channel)
c1  output  1  decoded control bit 1 (vsync on the blue channel)
de  output  1  data enable; 1 while the current word is a data word
bitslip  output  1  single-cycle request to the deserializer to shift its boundary by 1 bit
slip_cnt  output  4  number of slips since the last search start, range 0..9
locked  output  1  word alignment achieved

Behaviour:
- Reset (asynchronous, rst_n=0): state=SEARCH; all counters 0; dout=0, c0=0, c1=0, de=0, bitslip=0, slip_cnt=0, locked=0.
- Stage 1 (registered): capture din; flag tok_vld when din matches one of four tokens. Patterns are written din[9:0]:
  - 10'b1101010100 -> c1c0=00
  - 10'b0010101011 -> c1c0=01
  - 10'b0101010100 -> c1c0=10
  - 10'b1010101011 -> c1c0=11
- Stage 2 (registered): decode. Latency from din to dout/c0/c1/de is exactly 2 cycles.
  - q = din[9] ? ~din[7:0] : din[7:0]
  - d[0] = q[0]
  - for i = 1..7: d[i] = din[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1])
- Output rules:
  - locked=0: de=0, dout=0, c0/c1=0.
  - locked=1 and token word: de=0, dout=0, c0/c1 take the token value.
  - locked=1 and non-token word: de=1, dout=d, c0/c1 hold their last token value.
- Control words are classified by the token patterns only; TERC4/guard-band words are treated as data.
- FSM, state SEARCH:
  - run_cnt counts consecutive tok_vld cycles; it clears to 0 on any non-token word.
  - tmo_cnt increments every cycle.
  - run_cnt reaching CTRL_RUN -> LOCKED; locked=1 from the next cycle.
  - else tmo_cnt reaching SEARCH_TIMEOUT-1 -> SLIP.
  - If both happen in the same cycle, lock wins.
- FSM, state SLIP:
  - bitslip=1 for exactly one cycle.
  - slip_cnt increments, wrapping 9 -> 0.
  - Next state WAIT.
- FSM, state WAIT:
  - Counts SLIP_WAIT cycles; token detection is ignored.
  - Then -> SEARCH with run_cnt=0 and tmo_cnt=0.
- FSM, state LOCKED:
  - loss_cnt clears on every tok_vld and increments otherwise.
  - loss_cnt reaching LOSS_TIMEOUT -> SEARCH; locked=0 next cycle; slip_cnt unchanged; de forced 0 from the same cycle locked falls.
- bitslip is never asserted outside SLIP and never on two consecutive cycles.
- Counter widths are $clog2(param)+1. No counter wraps except slip_cnt.
- Reset asserted in any state returns immediately to reset values; a pending slip is abandoned.

Decomposition:
- Shared package tmds_pkg holds:
  - the four 10-bit token constants (also used by the encode block)
  - the FSM state enum {SEARCH, SLIP, WAIT, LOCKED}
  - a function tmds_dec8(din[9:0]) returning the 8-bit decode.
- One natural sub-module: tmds_align_fsm, containing the state machine and counters and producing locked/bitslip/slip_cnt. The datapath stays in the top module.

Test Plan:
1. Reset, then 8 consecutive 10'b1101010100 -> locked=1 one cycle after the 8th token is registered; de=0, c0=c1=0; bitslip never pulses.
2. After lock, 10'b0100000000 then 10'b1011111111 -> 2 cycles later de=1 with dout=8'h00, then de=1 with dout=8'hFE; c0/c1 hold 00.
3. Bench deserializer model rotates its word by 1 bit per bitslip pulse and starts 3 bits off; stream is repeating token bursts of 16 -> exactly 3 bitslip pulses spaced SEARCH_TIMEOUT+SLIP_WAIT+1 cycles apart; slip_cnt=3; then locked=1.
4. 7 tokens, 1 data word, 7 tokens, repeated for 3000 cycles -> locked stays 0; one bitslip at cycle 2048.
5. Locked, then 4096 data words with no tokens -> locked falls; de=0 on the following cycles; FSM back in SEARCH; a later 8-token run relocks with no slip.
6. rst_n pulsed low for 1 cycle while in LOCKED during active data -> all outputs 0 immediately; relock only after a fresh run of 8 tokens.
